// File: rtl/dbg_ctrl_pkg.sv
// Shared types and constants for the debug halt controller.
//   dbg_state_e    : halt-controller FSM state encoding
//   AddrW          : instruction address width
//   DefaultTimeout : default acknowledge timeout in cycles
//   DefaultCntW    : default width of the completed-halt counter
package dbg_ctrl_pkg;

    localparam int unsigned AddrW          = 32;
    localparam int unsigned DefaultTimeout = 64;
    localparam int unsigned DefaultCntW    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHalted,
        StResume,
        StError
    } dbg_state_e;

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Acknowledge wait counter for the debug halt controller.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronously zero the count (wins over enable_i)
//   enable_i      : count one cycle
//   expired_o     : high while enabled in the TIMEOUT-th counted cycle
module dbg_timeout_cnt #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LastCnt);

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug halt controller: requests a core halt, tracks the acknowledge, resumes the
// core and flags acknowledge timeouts.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   fetch_enable_i   : SoC fetch enable, gated off in ERROR -> fetch_enable_o
//   halt_req_i       : level request to halt the core
//   resume_req_i     : level request to leave debug mode (honoured only when halted)
//   clear_i          : leave ERROR
//   debug_mode_i     : core reports it is in debug mode
//   instr_addr_i     : core fetch address, captured into halt_pc_o on halt acknowledge
//   debug_req_o      : debug request to the core
//   resume_o         : resume request to the debug unit
//   halted_o         : core confirmed halted (also while resuming)
//   timeout_o        : acknowledge timed out
//   halt_pc_o        : address captured at the last halt
//   halt_cnt_o       : saturating count of completed halts
module dbg_halt_ctrl
    import dbg_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout,
    parameter int unsigned CNT_W   = DefaultCntW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fetch_enable_i,
    input  logic             halt_req_i,
    input  logic             resume_req_i,
    input  logic             clear_i,
    input  logic             debug_mode_i,
    input  logic [AddrW-1:0] instr_addr_i,
    output logic             debug_req_o,
    output logic             resume_o,
    output logic             fetch_enable_o,
    output logic             halted_o,
    output logic             timeout_o,
    output logic [AddrW-1:0] halt_pc_o,
    output logic [CNT_W-1:0] halt_cnt_o
);

    dbg_state_e       state_q, state_d;
    logic [AddrW-1:0] halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0] halt_cnt_q, halt_cnt_d;
    logic             capture;
    logic             wait_active;
    logic             expired;

    // The wait counter only runs while waiting on the core; it sits at zero otherwise,
    // so every entry into REQ or RESUME starts from a fresh count.
    assign wait_active = (state_q == StReq) || (state_q == StResume);

    dbg_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (!wait_active),
        .enable_i  (wait_active),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                // Core entered debug by itself: record the halt without requesting it.
                if (debug_mode_i) begin
                    state_d = StHalted;
                    capture = 1'b1;
                end else if (halt_req_i) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // Acknowledge beats a timeout expiring on the same edge.
                if (debug_mode_i) begin
                    state_d = StHalted;
                    capture = 1'b1;
                end else if (expired) begin
                    state_d = StError;
                end
            end
            StHalted: begin
                if (resume_req_i) begin
                    state_d = StResume;
                end
            end
            StResume: begin
                if (!debug_mode_i) begin
                    state_d = StIdle;
                end else if (expired) begin
                    state_d = StError;
                end
            end
            StError: begin
                if (clear_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        halt_pc_d  = halt_pc_q;
        halt_cnt_d = halt_cnt_q;
        if (capture) begin
            halt_pc_d = instr_addr_i;
            if (halt_cnt_q != '1) begin
                halt_cnt_d = halt_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            halt_pc_q  <= '0;
            halt_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            halt_pc_q  <= halt_pc_d;
            halt_cnt_q <= halt_cnt_d;
        end
    end

    // Status outputs decode the registered state, so they are glitch-free and the
    // asynchronous reset clears them without a clock edge.
    always_comb begin
        debug_req_o    = (state_q == StReq);
        resume_o       = (state_q == StResume);
        halted_o       = (state_q == StHalted) || (state_q == StResume);
        timeout_o      = (state_q == StError);
        fetch_enable_o = fetch_enable_i && (state_q != StError);
    end

    assign halt_pc_o  = halt_pc_q;
    assign halt_cnt_o = halt_cnt_q;

endmodule

// File: doc/dbg_halt_ctrl.md
DBG_HALT_CTRL -- requirements
Module: dbg_halt_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk_i and rst_ni.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the number of cycles allowed for a core acknowledge (valid range 2..65535).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the halt counter.
REQ-004 clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 fetch_enable_i  in  1  fetch enable from SoC level.
REQ-007 halt_req_i  in  1  request to halt the core into debug mode (level).
REQ-008 resume_req_i  in  1  request to leave debug mode (level).
REQ-009 clear_i  in  1  clears the ERROR state.
REQ-010 debug_mode_i  in  1  core status: 1 = core is in debug mode.
REQ-011 instr_addr_i  in  32  core instruction fetch address.
REQ-012 debug_req_o  out  1  debug request to the core debug_req_i.
REQ-013 resume_o  out  1  resume request to the debug unit.
REQ-014 fetch_enable_o  out  1  gated fetch enable to the core.
REQ-015 halted_o  out  1  core confirmed halted.
REQ-016 timeout_o  out  1  acknowledge timeout occurred.
REQ-017 halt_pc_o  out  32  instr_addr_i captured on halt acknowledge.
REQ-018 halt_cnt_o  out  CNT_W  number of completed halts.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, HALTED, RESUME and ERROR.
REQ-020 IDLE: all status outputs 0; halt_req_i=1 SHALL move to REQ on the next edge, clearing the wait counter.
REQ-021 REQ: debug_req_o=1 registered, i.e. asserted in the first cycle after halt_req_i is sampled; wait counter increments every cycle.
REQ-022 REQ with debug_mode_i=1 SHALL move to HALTED, capture instr_addr_i into halt_pc_o on the same edge, and increment halt_cnt_o.
REQ-023 halt_cnt_o SHALL saturate at all-ones, never wrapping.
REQ-024 REQ with wait counter reaching TIMEOUT-1 and debug_mode_i=0 SHALL move to ERROR; if both occur on the same edge, the acknowledge SHALL win.
REQ-025 HALTED: debug_req_o=0, halted_o=1; halt_req_i is ignored; resume_req_i=1 SHALL move to RESUME with the wait counter cleared.
REQ-026 RESUME: resume_o=1, halted_o=1; debug_mode_i=0 SHALL move to IDLE; timeout per REQ-024 SHALL move to ERROR.
REQ-027 ERROR: timeout_o=1, debug_req_o=0, resume_o=0, fetch_enable_o=0; clear_i=1 SHALL move to IDLE and clear timeout_o.
REQ-028 fetch_enable_o SHALL equal fetch_enable_i in all states except ERROR (combinational AND with state decode).
REQ-029 resume_req_i outside HALTED SHALL be ignored; in IDLE, simultaneous halt_req_i and resume_req_i SHALL enter REQ.
REQ-030 If debug_mode_i=1 in IDLE (core entered debug on its own), the FSM SHALL go directly to HALTED and capture halt_pc_o, without asserting debug_req_o.
REQ-031 halt_pc_o SHALL hold its value until the next halt acknowledge.

Reset
REQ-032 rst_ni=0 SHALL immediately force state IDLE and clear all outputs, halt_pc_o, halt_cnt_o and the wait counter, including mid-REQ or mid-RESUME.
REQ-033 After rst_ni rises, the first state change SHALL occur no earlier than the first rising clk_i edge.

Structure
REQ-034 Package dbg_ctrl_pkg SHALL hold the state enum type, the default TIMEOUT and CNT_W values, and the 32-bit address width constant.
REQ-035 The wait counter SHALL be a sub-module dbg_timeout_cnt (clear, enable, expired outputs; width $clog2(TIMEOUT)).

Verification
REQ-036 Halt: halt_req_i=1 at t0, debug_mode_i=1 three cycles later, instr_addr_i=0x0000_0080 -> debug_req_o high for 3 cycles, halted_o=1, halt_pc_o=0x80, halt_cnt_o=1.
REQ-037 Resume: from HALTED, resume_req_i=1, debug_mode_i drops two cycles later -> resume_o high for 2 cycles, then IDLE with halted_o=0.
REQ-038 Timeout: TIMEOUT=8, halt_req_i=1, debug_mode_i held at 0 -> ERROR after 8 cycles in REQ, timeout_o=1, fetch_enable_o=0; clear_i returns the FSM to IDLE.
REQ-039 Race: ack arrives on the TIMEOUT-1 cycle -> HALTED with timeout_o=0.
REQ-040 Saturation: CNT_W=2, five halt/resume sequences -> halt_cnt_o=3.
REQ-041 Reset mid-REQ: rst_ni=0 while debug_req_o=1 -> debug_req_o=0 with no clock edge and all counters 0.
